program_ram_loader: RTL and testbench

//   Writer side of the CPU instruction-fetch interface. It holds a 16x4 program RAM that the

---
 rtl/program_ram_loader.sv | 93 +++++++++
 tb/tb_program_ram_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/program_ram_loader.sv
// program_ram_loader: switch-loaded program RAM with debounced write strobe and CPU hold control
module program_ram_loader #(
   parameter int ADDR_WIDTH      = 4,
   parameter int DATA_WIDTH      = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  loadEn,
   input  logic                  strobe,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic [ADDR_WIDTH-1:0] fetchAddr,
   output logic [DATA_WIDTH-1:0] fetchData,
   output logic                  cpuHold,
   output logic [ADDR_WIDTH-1:0] writePtr,
   output logic                  loadDone
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] ptr_n;
   logic [CW-1:0]         cnt;
   logic                  s1, s2, deb, deb_q, le_q;
   logic                  wr_pulse, le_rise, we;
   assign wr_pulse  = deb & ~deb_q;
   assign le_rise   = loadEn & ~le_q;
   assign fetchData = mem[fetchAddr];
   // synchronise and debounce the push-button; the level flips only after a full stable run
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         deb   <= 1'b0;
         deb_q <= 1'b0;
         le_q  <= 1'b0;
      end else begin
         s1    <= strobe;
         s2    <= s1;
         deb_q <= deb;
         le_q  <= loadEn;
         if (s2 == deb) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            deb <= s2;
         end else cnt <= cnt + 1'b1;
      end
   end
   // next-state, pointer and write-enable decode
   always_comb begin
      state_n = state;
      ptr_n   = writePtr;
      we      = 1'b0;
      case (state)
         IDLE: begin
            state_n = le_rise ? LOAD : IDLE;
            ptr_n   = le_rise ? '0 : writePtr;
         end
         LOAD: begin
            we      = wr_pulse;
            ptr_n   = wr_pulse ? writePtr + 1'b1 : writePtr;
            state_n = ((wr_pulse && writePtr == '1) || !loadEn) ? RUN : LOAD;
         end
         RUN: begin
            state_n = le_rise ? LOAD : RUN;
            ptr_n   = le_rise ? '0 : writePtr;
         end
         default: state_n = IDLE;
      endcase
   end
   // state register with registered hold/done decodes of the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         writePtr <= '0;
         cpuHold  <= 1'b1;
         loadDone <= 1'b0;
      end else begin
         state    <= state_n;
         writePtr <= ptr_n;
         cpuHold  <= state_n != RUN;
         loadDone <= state_n == RUN;
      end
   end
   // program RAM: whole-array clear on reset, single write port while loading
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) mem[writePtr] <= dataIn;
   end
endmodule

// File: tb/tb_program_ram_loader.sv
// tb_program_ram_loader: directed checks of load, debounce, early exit, reload and reset
`timescale 1ns/1ps
module tb_program_ram_loader;
   logic       clk = 1'b0;
   logic       reset, loadEn, strobe;
   logic [3:0] dataIn, fetchAddr, fetchData, writePtr;
   logic       cpuHold, loadDone;
   logic [3:0] exp_mem [16];
   int         n_cmp = 0;
   int         n_fail = 0;

   program_ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .loadEn(loadEn), .strobe(strobe), .dataIn(dataIn),
      .fetchAddr(fetchAddr), .fetchData(fetchData), .cpuHold(cpuHold),
      .writePtr(writePtr), .loadDone(loadDone)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      dataIn = d;
      strobe = 1'b1;
      cyc(10);
      strobe = 1'b0;
      cyc(10);
   endtask

   task automatic test_reset;
      reset = 1'b1; loadEn = 1'b0; strobe = 1'b0; dataIn = 4'h0; fetchAddr = 4'h0;
      cyc(2);
      n_cmp++; if (cpuHold !== 1'b1) begin n_fail++; $display("FAIL reset_hold got %b want 1", cpuHold); end
      n_cmp++; if (loadDone !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", loadDone); end
      n_cmp++; if (writePtr !== 4'h0) begin n_fail++; $display("FAIL reset_ptr got %h want 0", writePtr); end
      for (int i = 0; i < 16; i++) begin
         fetchAddr = 4'(i); #0.1;
         n_cmp++; if (fetchData !== 4'h0) begin n_fail++; $display("FAIL reset_mem[%0d] got %h want 0", i, fetchData); end
         exp_mem[i] = 4'h0;
      end
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic test_full_load;
      loadEn = 1'b1;
      cyc(1);
      dataIn = 4'hF; strobe = 1'b1;
      cyc(6);
      n_cmp++; if (writePtr !== 4'h0) begin n_fail++; $display("FAIL latency_early got %h want 0", writePtr); end
      cyc(1);
      n_cmp++; if (writePtr !== 4'h1) begin n_fail++; $display("FAIL latency_write got %h want 1", writePtr); end
      cyc(3); strobe = 1'b0; cyc(10);
      exp_mem[0] = 4'hF;
      for (int i = 1; i < 16; i++) begin
         press(4'hF - 4'(i));
         exp_mem[i] = 4'hF - 4'(i);
      end
      n_cmp++; if (cpuHold !== 1'b0) begin n_fail++; $display("FAIL full_hold got %b want 0", cpuHold); end
      n_cmp++; if (loadDone !== 1'b1) begin n_fail++; $display("FAIL full_done got %b want 1", loadDone); end
      n_cmp++; if (writePtr !== 4'h0) begin n_fail++; $display("FAIL full_ptr got %h want 0", writePtr); end
      fetchAddr = 4'h3; #0.1;
      n_cmp++; if (fetchData !== 4'hC) begin n_fail++; $display("FAIL full_addr3 got %h want c", fetchData); end
      for (int i = 0; i < 16; i++) begin
         fetchAddr = 4'(i); #0.1;
         n_cmp++; if (fetchData !== exp_mem[i]) begin n_fail++; $display("FAIL full_mem[%0d] got %h want %h", i, fetchData, exp_mem[i]); end
      end
   endtask

   task automatic test_bounce;
      loadEn = 1'b0; cyc(1);
      loadEn = 1'b1; cyc(1);
      dataIn = 4'h5;
      strobe = 1'b1; cyc(1); strobe = 1'b0; cyc(1);
      strobe = 1'b1; cyc(1); strobe = 1'b0; cyc(1);
      strobe = 1'b1; cyc(10);
      strobe = 1'b0; cyc(10);
      exp_mem[0] = 4'h5;
      n_cmp++; if (writePtr !== 4'h1) begin n_fail++; $display("FAIL bounce_ptr got %h want 1", writePtr); end
      for (int i = 0; i < 3; i++) begin
         fetchAddr = 4'(i); #0.1;
         n_cmp++; if (fetchData !== exp_mem[i]) begin n_fail++; $display("FAIL bounce_mem[%0d] got %h want %h", i, fetchData, exp_mem[i]); end
      end
   endtask

   task automatic test_early_exit;
      loadEn = 1'b0; cyc(1);
      loadEn = 1'b1; cyc(1);
      n_cmp++; if (cpuHold !== 1'b1 || writePtr !== 4'h0) begin n_fail++; $display("FAIL early_enter hold %b ptr %h want 1 0", cpuHold, writePtr); end
      press(4'h1); exp_mem[0] = 4'h1;
      press(4'h2); exp_mem[1] = 4'h2;
      dataIn = 4'h3; strobe = 1'b1;
      cyc(6);
      fetchAddr = 4'h2; #0.1;
      n_cmp++; if (fetchData !== 4'hD) begin n_fail++; $display("FAIL same_cycle_old got %h want d", fetchData); end
      loadEn = 1'b0;
      cyc(1);
      exp_mem[2] = 4'h3;
      n_cmp++; if (fetchData !== 4'h3) begin n_fail++; $display("FAIL same_cycle_new got %h want 3", fetchData); end
      n_cmp++; if (cpuHold !== 1'b0) begin n_fail++; $display("FAIL early_hold got %b want 0", cpuHold); end
      n_cmp++; if (loadDone !== 1'b1) begin n_fail++; $display("FAIL early_done got %b want 1", loadDone); end
      n_cmp++; if (writePtr !== 4'h3) begin n_fail++; $display("FAIL early_ptr got %h want 3", writePtr); end
      cyc(3); strobe = 1'b0; cyc(10);
      for (int i = 0; i < 16; i++) begin
         fetchAddr = 4'(i); #0.1;
         n_cmp++; if (fetchData !== exp_mem[i]) begin n_fail++; $display("FAIL early_mem[%0d] got %h want %h", i, fetchData, exp_mem[i]); end
      end
   endtask

   task automatic test_reload;
      press(4'h9);
      n_cmp++; if (writePtr !== 4'h3) begin n_fail++; $display("FAIL run_ptr got %h want 3", writePtr); end
      n_cmp++; if (cpuHold !== 1'b0) begin n_fail++; $display("FAIL run_hold got %b want 0", cpuHold); end
      for (int i = 0; i < 16; i++) begin
         fetchAddr = 4'(i); #0.1;
         n_cmp++; if (fetchData !== exp_mem[i]) begin n_fail++; $display("FAIL run_mem[%0d] got %h want %h", i, fetchData, exp_mem[i]); end
      end
      loadEn = 1'b1;
      cyc(1);
      n_cmp++; if (cpuHold !== 1'b1) begin n_fail++; $display("FAIL reload_hold got %b want 1", cpuHold); end
      n_cmp++; if (loadDone !== 1'b0) begin n_fail++; $display("FAIL reload_done got %b want 0", loadDone); end
      n_cmp++; if (writePtr !== 4'h0) begin n_fail++; $display("FAIL reload_ptr got %h want 0", writePtr); end
   endtask

   task automatic test_mid_reset;
      for (int i = 0; i < 5; i++) press(4'h6 + 4'(i));
      n_cmp++; if (writePtr !== 4'h5) begin n_fail++; $display("FAIL mid_ptr got %h want 5", writePtr); end
      fetchAddr = 4'h4; #0.1;
      n_cmp++; if (fetchData !== 4'hA) begin n_fail++; $display("FAIL mid_mem4 got %h want a", fetchData); end
      reset = 1'b1; cyc(1); reset = 1'b0;
      n_cmp++; if (cpuHold !== 1'b1) begin n_fail++; $display("FAIL mid_reset_hold got %b want 1", cpuHold); end
      n_cmp++; if (loadDone !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done got %b want 0", loadDone); end
      n_cmp++; if (writePtr !== 4'h0) begin n_fail++; $display("FAIL mid_reset_ptr got %h want 0", writePtr); end
      for (int i = 0; i < 16; i++) begin
         fetchAddr = 4'(i); #0.1;
         n_cmp++; if (fetchData !== 4'h0) begin n_fail++; $display("FAIL mid_reset_mem[%0d] got %h want 0", i, fetchData); end
      end
      press(4'h7);
      n_cmp++; if (writePtr !== 4'h1) begin n_fail++; $display("FAIL direct_load_ptr got %h want 1", writePtr); end
      fetchAddr = 4'h0; #0.1;
      n_cmp++; if (fetchData !== 4'h7) begin n_fail++; $display("FAIL direct_load_mem0 got %h want 7", fetchData); end
   endtask

   initial begin
      test_reset;
      test_full_load;
      test_bounce;
      test_early_exit;
      test_reload;
      test_mid_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
